// File: rtl/serial_adder_ctrl_if.sv
// +-----------------------------------------------------------------------------
// | Module  : serial_adder_ctrl_if
// | Brief   : Operand/result bundle between an operand source and the serial adder.
// | Revision: 1.0 - initial release
// +-----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, overflow
  );
endinterface

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// +-----------------------------------------------------------------------------
// | Module  : serial_adder_ctrl
// | Brief   : Bit-serial add/subtract, one full-adder cell stepped LSB first.
// | Revision: 1.0 - initial release
// +-----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);

  localparam int            CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_opa, w_opa;
  logic [WIDTH-1:0] r_opb, w_opb;
  logic [WIDTH-1:0] r_sum, w_sum;
  logic [WIDTH-1:0] w_sum_shift;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic             r_carry, w_carry;
  logic             r_cout, w_cout;
  logic             r_ovf, w_ovf;
  logic             w_s, w_c;
  logic             w_cin_msb;
  logic             w_accept;

  // Full-adder cell: X = opA LSB, Y = opB LSB, Z = registered carry.
  assign w_s = r_opa[0] ^ r_opb[0] ^ r_carry;
  assign w_c = (r_opa[0] & r_opb[0]) | (r_carry & (r_opa[0] ^ r_opb[0]));

  // Carry into the MSB: captured one bit early, or the cell's own carry-in at WIDTH==1.
  generate
    if (WIDTH > 1) begin : g_cmsb_reg
      localparam logic [CW-1:0] c_msb_m1 = CW'(WIDTH - 2);
      logic r_cmsb;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cmsb <= 1'b0;
        end else if (r_state == S_RUN && r_cnt == c_msb_m1) begin
          r_cmsb <= w_c;
        end
      end
      assign w_cin_msb = r_cmsb;
    end else begin : g_cmsb_direct
      assign w_cin_msb = r_carry;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_opa   <= w_opa;
      r_opb   <= w_opb;
      r_sum   <= w_sum;
      r_cnt   <= w_cnt;
      r_carry <= w_carry;
      r_cout  <= w_cout;
      r_ovf   <= w_ovf;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_opa       = r_opa;
    w_opb       = r_opb;
    w_sum       = r_sum;
    w_cnt       = r_cnt;
    w_carry     = r_carry;
    w_cout      = r_cout;
    w_ovf       = r_ovf;
    w_accept    = 1'b0;
    // New bit enters at the MSB so the LSB lands in bit 0 after WIDTH shifts.
    w_sum_shift = r_sum >> 1;
    w_sum_shift[WIDTH-1] = w_s;

    case (r_state)
      S_IDLE: begin
        w_accept = bus.start;
      end
      S_RUN: begin
        w_opa   = r_opa >> 1;
        w_opb   = r_opb >> 1;
        w_sum   = w_sum_shift;
        w_carry = w_c;
        if (r_cnt == c_last) begin
          w_cout  = w_c;
          w_ovf   = w_c ^ w_cin_msb;
          w_state = S_DONE;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        w_accept = bus.start;
        w_state  = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
    if (w_accept) begin
      w_state = S_RUN;
      w_opa   = bus.a;
      w_opb   = bus.sub ? ~bus.b : bus.b;
      w_carry = bus.sub;
      w_cnt   = '0;
      w_sum   = '0;
    end
  end

  assign bus.busy     = (r_state == S_RUN);
  assign bus.done     = (r_state == S_DONE);
  assign bus.sum      = r_sum;
  assign bus.cout     = r_cout;
  assign bus.overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances checked
// against an integer-arithmetic reference through per-instance scoreboards.
`timescale 1ns/1ps
`default_nettype none

module tb_serial_adder_ctrl;

  logic clk;
  logic rst;

  serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb8[$];
  exp_t sb1[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic sub);
    exp_t   e;
    longint mask, ua, ub, sa, sb, r, rs, smax, smin;
    mask = (64'sd1 <<< w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = a[w-1] ? ua - (64'sd1 <<< w) : ua;
    sb   = b[w-1] ? ub - (64'sd1 <<< w) : ub;
    r    = sub ? ua - ub : ua + ub;
    rs   = sub ? sa - sb : sa + sb;
    smax = (64'sd1 <<< (w - 1)) - 1;
    smin = -(64'sd1 <<< (w - 1));
    e.sum  = 32'(r & mask);
    e.cout = sub ? (ua >= ub) : (((r >>> w) & 1) != 0);
    e.ovf  = (rs > smax) || (rs < smin);
    return e;
  endfunction

  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic sub);
    bus8.a = a; bus8.b = b; bus8.sub = sub; bus8.start = 1'b1;
    sb8.push_back(model(8, 32'(a), 32'(b), sub));
    @(posedge clk); #1;
    bus8.start = 1'b0;
  endtask

  task automatic go1(input logic a, input logic b, input logic sub);
    bus1.a = a; bus1.b = b; bus1.sub = sub; bus1.start = 1'b1;
    sb1.push_back(model(1, 32'(a), 32'(b), sub));
    @(posedge clk); #1;
    bus1.start = 1'b0;
  endtask

  task automatic wait8(output int nbusy, output bit seen);
    nbusy = 0; seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      if (bus8.done) seen = 1'b1;
      else begin
        if (bus8.busy) nbusy++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait1(output int nbusy, output bit seen);
    nbusy = 0; seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      if (bus1.done) seen = 1'b1;
      else begin
        if (bus1.busy) nbusy++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34; bus8.sub = 1'b0;
    bus1.start = 1'b1; bus1.a = 1'b1;  bus1.b = 1'b1;  bus1.sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus8.start = 1'b0; bus1.start = 1'b0;
    rst = 1'b0;
    checks++;
    if ({bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.overflow} !== 12'h000) begin
      errors++;
      $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.overflow);
    end
    checks++;
    if ({bus1.busy, bus1.done, bus1.sum, bus1.cout, bus1.overflow} !== 5'b00000) begin
      errors++;
      $display("FAIL reset1: got busy=%b done=%b sum=%b cout=%b ovf=%b want all 0",
               bus1.busy, bus1.done, bus1.sum, bus1.cout, bus1.overflow);
    end
    @(posedge clk); #1;
    checks++;
    if (bus8.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_wins_start: busy got %b want 0", bus8.busy);
    end
  endtask

  task automatic test_ops(input string name, input logic [7:0] a, input logic [7:0] b, input logic sub);
    int   nb;
    bit   seen;
    exp_t e;
    go8(a, b, sub);
    wait8(nb, seen);
    checks++;
    if (!seen || nb != 8) begin
      errors++;
      $display("FAIL %s_latency: got busy_cycles=%0d done_seen=%b want 8 and 1", name, nb, seen);
    end
    e = sb8.pop_front();
    checks++;
    if ({bus8.sum, bus8.cout, bus8.overflow} !== {e.sum[7:0], e.cout, e.ovf}) begin
      errors++;
      $display("FAIL %s_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               name, bus8.sum, bus8.cout, bus8.overflow, e.sum[7:0], e.cout, e.ovf);
    end
    @(posedge clk); #1;
    checks++;
    if (bus8.done !== 1'b0 || bus8.busy !== 1'b0 || bus8.sum !== e.sum[7:0]) begin
      errors++;
      $display("FAIL %s_pulse: got done=%b busy=%b sum=%h want 0 0 %h",
               name, bus8.done, bus8.busy, bus8.sum, e.sum[7:0]);
    end
  endtask

  task automatic test_add();
    test_ops("add_5a_3c", 8'h5A, 8'h3C, 1'b0);
    checks++;
    if ({bus8.sum, bus8.cout, bus8.overflow} !== {8'h96, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add_5a_3c_const: got sum=%h cout=%b ovf=%b want 96 0 1",
               bus8.sum, bus8.cout, bus8.overflow);
    end
    test_ops("add_ff_01", 8'hFF, 8'h01, 1'b0);
    test_ops("add_7f_01", 8'h7F, 8'h01, 1'b0);
  endtask

  task automatic test_sub();
    test_ops("sub_10_20", 8'h10, 8'h20, 1'b1);
    test_ops("sub_80_01", 8'h80, 8'h01, 1'b1);
    checks++;
    if ({bus8.sum, bus8.cout, bus8.overflow} !== {8'h7F, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sub_80_01_const: got sum=%h cout=%b ovf=%b want 7f 1 1",
               bus8.sum, bus8.cout, bus8.overflow);
    end
  endtask

  task automatic test_back_to_back();
    int   nb;
    bit   seen;
    exp_t e;
    go8(8'h01, 8'h02, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    bus8.a = 8'hAA; bus8.b = 8'h55; bus8.sub = 1'b1; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    wait8(nb, seen);
    e = sb8.pop_front();
    checks++;
    if (!seen || bus8.sum !== e.sum[7:0] || sb8.size() != 0) begin
      errors++;
      $display("FAIL ignore_start_in_run: got done=%b sum=%h queued=%0d want 1 %h 0",
               seen, bus8.sum, sb8.size(), e.sum[7:0]);
    end
    go8(8'h04, 8'h04, 1'b0);
    checks++;
    if (bus8.done !== 1'b0 || bus8.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got done=%b busy=%b want 0 1", bus8.done, bus8.busy);
    end
    wait8(nb, seen);
    e = sb8.pop_front();
    checks++;
    if (!seen || nb != 8 || bus8.sum !== e.sum[7:0] || bus8.sum !== 8'h08) begin
      errors++;
      $display("FAIL b2b_result: got done=%b busy_cycles=%0d sum=%h want 1 8 %h",
               seen, nb, bus8.sum, e.sum[7:0]);
    end
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus8.done || bus8.busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL b2b_no_queue: got extra activity=1 want 0");
    end
  endtask

  task automatic test_reset_mid_run();
    int   nb;
    bit   seen;
    exp_t e;
    go8(8'h80, 8'h80, 1'b0);
    wait8(nb, seen);
    e = sb8.pop_front();
    checks++;
    if (!seen || {bus8.sum, bus8.cout, bus8.overflow} !== {e.sum[7:0], e.cout, e.ovf}) begin
      errors++;
      $display("FAIL pre_reset_op: got sum=%h cout=%b ovf=%b want %h %b %b",
               bus8.sum, bus8.cout, bus8.overflow, e.sum[7:0], e.cout, e.ovf);
    end
    go8(8'h33, 8'h44, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb8.delete();
    checks++;
    if ({bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.overflow} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_run: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.overflow);
    end
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus8.done) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_no_done: got done pulse=1 want 0");
    end
    test_ops("after_reset", 8'h01, 8'h01, 1'b0);
    checks++;
    if (bus8.sum !== 8'h02) begin
      errors++;
      $display("FAIL after_reset_const: got sum=%h want 02", bus8.sum);
    end
  endtask

  task automatic test_width1();
    int   nb;
    bit   seen;
    exp_t e;
    go1(1'b1, 1'b1, 1'b0);
    wait1(nb, seen);
    e = sb1.pop_front();
    checks++;
    if (!seen || nb != 1 || {bus1.sum, bus1.cout, bus1.overflow} !== {e.sum[0], e.cout, e.ovf}
        || bus1.sum !== 1'b0 || bus1.cout !== 1'b1) begin
      errors++;
      $display("FAIL w1_basic: got done=%b busy=%0d sum=%b cout=%b ovf=%b want 1 1 %b %b %b",
               seen, nb, bus1.sum, bus1.cout, bus1.overflow, e.sum[0], e.cout, e.ovf);
    end
    for (int i = 0; i < 8; i++) begin
      go1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait1(nb, seen);
      e = sb1.pop_front();
      checks++;
      if (!seen || nb != 1 || {bus1.sum, bus1.cout, bus1.overflow} !== {e.sum[0], e.cout, e.ovf}) begin
        errors++;
        $display("FAIL w1_rand%0d: got done=%b sum=%b cout=%b ovf=%b want 1 %b %b %b",
                 i, seen, bus1.sum, bus1.cout, bus1.overflow, e.sum[0], e.cout, e.ovf);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random8();
    int   nb;
    bit   seen;
    exp_t e;
    for (int i = 0; i < 20; i++) begin
      go8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      // Operand/sub churn mid-run must not disturb the latched operation.
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.sub = ~bus8.sub;
      wait8(nb, seen);
      e = sb8.pop_front();
      checks++;
      if (!seen || {bus8.sum, bus8.cout, bus8.overflow} !== {e.sum[7:0], e.cout, e.ovf}) begin
        errors++;
        $display("FAIL rand8_%0d: got done=%b sum=%h cout=%b ovf=%b want 1 %h %b %b",
                 i, seen, bus8.sum, bus8.cout, bus8.overflow, e.sum[7:0], e.cout, e.ovf);
      end
      if (i % 2 == 0) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus8.start = 1'b0; bus8.sub = 1'b0; bus8.a = '0; bus8.b = '0;
    bus1.start = 1'b0; bus1.sub = 1'b0; bus1.a = '0; bus1.b = '0;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_mid_run();
    test_width1();
    test_random8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
